// File: rtl/stopwatch_ctrl.sv
// -----------------------------------------------------------------------------
// stopwatch_ctrl
//   Minutes:seconds stopwatch controller with button debounce and an adjust
//   mode. All logic runs on clk; the divider outputs are sampled as levels
//   and turned into single-cycle ticks.
//
// Ports
//   clk        system clock
//   rst        asynchronous, active-high reset
//   clk_1hz    divider level, advances the count in RUN
//   clk_2hz    divider level, advances the selected field in ADJUST
//   clk_4hz    divider level, drives the display blink in ADJUST
//   clk_50hz   divider level, debounce sample strobe
//   btn_pause  raw pause/resume button (active-high)
//   btn_reset  raw clear button (active-high)
//   sw_adj     adjust-mode switch
//   sw_sel     adjust field select: 0 = minutes, 1 = seconds
//   minutes    minutes count 0-59
//   seconds    seconds count 0-59
//   running    high while in RUN
//   blank_min  blank the minutes digits
//   blank_sec  blank the seconds digits
// -----------------------------------------------------------------------------
module stopwatch_ctrl #(
  parameter int DEB_SAMPLES = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clk_1hz,
  input  logic       clk_2hz,
  input  logic       clk_4hz,
  input  logic       clk_50hz,
  input  logic       btn_pause,
  input  logic       btn_reset,
  input  logic       sw_adj,
  input  logic       sw_sel,
  output logic [5:0] minutes,
  output logic [5:0] seconds,
  output logic       running,
  output logic       blank_min,
  output logic       blank_sec
);

  localparam int            CW      = $clog2(DEB_SAMPLES + 1);
  localparam logic [CW-1:0] DEB_MAX = CW'(DEB_SAMPLES);
  localparam logic [CW-1:0] DEB_PRE = CW'(DEB_SAMPLES - 1);

  typedef enum logic [1:0] {IDLE, RUN, PAUSED, ADJUST} state_e;

  // ---------------------------------------------------------------------------
  // Divider edge detection: previous level registered, tick on 0->1.
  // ---------------------------------------------------------------------------
  logic [3:0] div_q;
  logic       tick_1hz, tick_2hz, tick_4hz, tick_50hz;

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge value of its neighbours.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) div_q <= '0;
    else     div_q <= {clk_50hz, clk_4hz, clk_2hz, clk_1hz};
  end

  assign tick_1hz  = clk_1hz  & ~div_q[0];
  assign tick_2hz  = clk_2hz  & ~div_q[1];
  assign tick_4hz  = clk_4hz  & ~div_q[2];
  assign tick_50hz = clk_50hz & ~div_q[3];

  // ---------------------------------------------------------------------------
  // Two-flop synchronizers, bit order {sel, adj, reset, pause}.
  // ---------------------------------------------------------------------------
  logic [3:0] sync1_q, sync2_q;
  logic       adj_s, sel_s;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= {sw_sel, sw_adj, btn_reset, btn_pause};
      sync2_q <= sync1_q;
    end
  end

  assign adj_s = sync2_q[2];
  assign sel_s = sync2_q[3];

  // ---------------------------------------------------------------------------
  // Debounce: index 0 = pause, 1 = reset. The counter saturates at
  // DEB_SAMPLES, so the DEB_PRE -> DEB_MAX step happens once per press.
  // ---------------------------------------------------------------------------
  logic [CW-1:0] deb_q [2];
  logic [1:0]    press_q;
  logic          pause_p, reset_p;

  // NOTE: the debounce counters are a tiny register array, not a memory, and
  // must be reset so a press interrupted by rst leaves no partial progress.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int b = 0; b < 2; b++) deb_q[b] <= '0;
      press_q <= '0;
    end else begin
      for (int b = 0; b < 2; b++) begin
        press_q[b] <= 1'b0;
        if (tick_50hz) begin
          if (sync2_q[b]) begin
            if (deb_q[b] != DEB_MAX) deb_q[b] <= deb_q[b] + 1'b1;
            if (deb_q[b] == DEB_PRE) press_q[b] <= 1'b1;
          end else begin
            deb_q[b] <= '0;
          end
        end
      end
    end
  end

  assign pause_p = press_q[0];
  assign reset_p = press_q[1];

  // ---------------------------------------------------------------------------
  // Next state and blink phase.
  // ---------------------------------------------------------------------------
  state_e state_q, state_d;
  logic   blink_q, blink_d;

  // NOTE: every always_comb output gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    if (adj_s) begin
      state_d = ADJUST;
    end else if (state_q == ADJUST) begin
      state_d = PAUSED;
    end else if (pause_p) begin
      case (state_q)
        IDLE:    state_d = RUN;
        RUN:     state_d = PAUSED;
        PAUSED:  state_d = RUN;
        default: state_d = state_q;
      endcase
    end else if (reset_p) begin
      state_d = IDLE;
    end
    blink_d = (state_d == ADJUST) ? (blink_q ^ tick_4hz) : 1'b0;
  end

  function automatic logic [5:0] inc60(input logic [5:0] v);
    return (v >= 6'd59) ? 6'd0 : v + 6'd1;
  endfunction

  // ---------------------------------------------------------------------------
  // State, counters and registered outputs.
  // ---------------------------------------------------------------------------
  logic [5:0] min_q, sec_q;
  logic       running_q, blank_min_q, blank_sec_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      min_q       <= '0;
      sec_q       <= '0;
      blink_q     <= 1'b0;
      running_q   <= 1'b0;
      blank_min_q <= 1'b0;
      blank_sec_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      blink_q     <= blink_d;
      running_q   <= (state_d == RUN);
      blank_min_q <= (state_d == ADJUST) && !sel_s && blink_d;
      blank_sec_q <= (state_d == ADJUST) &&  sel_s && blink_d;

      // Clear wins over any tick; a tick in RUN is still counted on the
      // cycle the pause pulse moves the FSM to PAUSED.
      if (reset_p) begin
        min_q <= '0;
        sec_q <= '0;
      end else if (state_q == RUN && tick_1hz) begin
        sec_q <= inc60(sec_q);
        if (sec_q >= 6'd59) min_q <= inc60(min_q);
      end else if (state_q == ADJUST && tick_2hz) begin
        if (sel_s) sec_q <= inc60(sec_q);
        else       min_q <= inc60(min_q);
      end
    end
  end

  assign minutes   = min_q;
  assign seconds   = sec_q;
  assign running   = running_q;
  assign blank_min = blank_min_q;
  assign blank_sec = blank_sec_q;

endmodule
